cv32e40p_mult_iter: RTL and testbench
=====================================

// Module: cv32e40p_mult_iter
// PURPOSE
//  Parametrised iterative integer multiplier: WIDTHxWIDTH -> 2*WIDTH product built from PART_W x PART_W
//  partial products, one per cycle, with optional accumulate (A*B + C). Returns low or high half
//  (MUL/MULH/MULHSU/MULHU/MAC). Sits in EX beside cv32e40p_mult; generalises its fixed 4-step MULH
//  sequence to any width/chunk size, with explicit valid/ready handshake and kill.
// PARAMETERS
//  WIDTH   32  operand width; WIDTH % PART_W == 0
//  PART_W  16  chunk width; NP = WIDTH/PART_W is a power of 2; NSTEP = NP*NP partial products
// PORTS
//  clk       in   1      clock
//  rst_n     in   1      reset; synchronous, active-low
//  valid_i   in   1      request valid
//  ready_o   out  1      block can accept a request this cycle
//  op_a_i    in   WIDTH  multiplicand A
//  op_b_i    in   WIDTH  multiplier B
//  op_c_i    in   WIDTH  accumulate addend C (zero-extended to 2*WIDTH)
//  acc_en_i  in   1      1: P = A*B + C; 0: P = A*B
//  signed_i  in   2      bit0: A signed, bit1: B signed; legal 00,01,11 (10 treated as 00)
//  high_i    in   1      1: result = P[2W-1:W]; 0: result = P[W-1:0]
//  kill_i    in   1      abort current operation (flush)
//  valid_o   out  1      result_o valid; held until ready_i
//  ready_i   in   1      consumer takes result (ex_ready)
//  result_o  out  WIDTH  result
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE, step 0, acc 0, result_o 0, valid_o 0; ready_o=1 next cycle.
//  FSM (cv32e40p_pkg::mult_iter_state_e): MI_IDLE, MI_BUSY, MI_DONE.
//   IDLE: ready_o=1. valid_i & ~kill_i -> latch A,B,signed,high; acc <= acc_en_i ? {0,C} : 0;
//         step <= 0; -> BUSY.
//   BUSY: ready_o=0. Each cycle step s: i = s % NP (A chunk), j = s / NP (B chunk).
//         chunk_a = A[i*PART_W +: PART_W], extended to PART_W+1 with sign bit = signed_i[0] & (i==NP-1)
//         & MSB; chunk_b likewise with signed_i[1], j. pp = signed (PART_W+1)x(PART_W+1) product,
//         sign-extended, << (i+j)*PART_W, acc <= acc + pp (mod 2^(2*WIDTH)).
//         After step NSTEP-1: result_o <= high ? acc'[2W-1:W] : acc'[W-1:0]; -> DONE.
//   DONE: valid_o=1, result_o stable. ready_i -> IDLE; ready_o = ready_i, so a new valid_i in the
//         same cycle is accepted and goes straight to BUSY (back-to-back, no bubble).
//  Latency: accept at edge T; valid_o high from T+NSTEP. NSTEP=1 (PART_W==WIDTH) is legal.
//  kill_i: highest priority in every state; next state IDLE, valid_o 0, acc/step cleared, no result;
//   a valid_i coincident with kill_i is not accepted. Inputs A/B/C may change while BUSY (latched).
//  signed_i=10: operands treated unsigned. Overflow of A*B+C beyond 2*WIDTH wraps silently.
//  ready_o, valid_o decoded from state (no comb path from valid_i); result_o registered.
// STRUCTURE
//  cv32e40p_pkg: mult_iter_state_e {MI_IDLE, MI_BUSY, MI_DONE}.
//  Sub-module cv32e40p_mult_pp: (PART_W+1)x(PART_W+1) signed multiplier, param PART_W, purely comb.
//  Top: FSM, step counter ($clog2(NSTEP), min 1 bit), operand regs, 2*WIDTH accumulator, result reg.
//  Elaboration-time assert on parameter legality.
// TESTING (WIDTH=32, PART_W=16 unless stated)
//  1 signed=11 high=1, A=B=32'h8000_0000 -> result 32'h4000_0000; valid_o exactly 4 cycles after accept.
//  2 signed=00, A=B=32'hFFFF_FFFF: high=1 -> 32'hFFFF_FFFE; high=0 -> 32'h0000_0001.
//  3 signed=01 high=1, A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> 32'hFFFF_FFFF; signed=11 same -> 32'h0.
//  4 acc_en=1 high=0, A=3, B=5, C=7 -> 22; acc_en=1 high=1, A=B=32'hFFFF_FFFF, C=32'hFFFF_FFFF,
//    signed=00 -> 32'hFFFF_FFFF.
//  5 kill_i at step 2 -> valid_o never rises, ready_o=1 next cycle; following op A=2,B=3 -> 6;
//    rst_n low mid-BUSY -> IDLE, valid_o 0, next op correct.
//  6 ready_i held low 5 cycles in DONE -> result stable; then ready_i & valid_i same cycle -> second
//    op accepted, valid 4 cycles later; PART_W=8 build: latency 16, test 1-3 values unchanged.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p execute-stage helpers.
// Holds the state encoding of the iterative multiplier FSM.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    MI_IDLE,
    MI_BUSY,
    MI_DONE
  } mult_iter_state_e;

endpackage

// File: rtl/cv32e40p_mult_pp.sv
// One signed (PART_W+1)x(PART_W+1) partial product.
// Unsigned chunks arrive with a zero in their extra top bit.
module cv32e40p_mult_pp #(
  parameter int PART_W = 16
) (
  input  logic signed [PART_W:0]     op_a,
  input  logic signed [PART_W:0]     op_b,
  output logic signed [2*PART_W+1:0] product
);

  assign product = (2*PART_W+2)'(op_a) * (2*PART_W+2)'(op_b);

endmodule

// File: rtl/cv32e40p_mult_iter.sv
// Iterative WIDTHxWIDTH multiplier with optional accumulate.
// Each cycle it adds one shifted PART_W chunk product into a 2*WIDTH accumulator.
module cv32e40p_mult_iter
  import cv32e40p_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PART_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [WIDTH-1:0] op_c_i,
  input  logic             acc_en_i,
  input  logic [1:0]       signed_i,
  input  logic             high_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int NP    = WIDTH / PART_W;
  localparam int NSTEP = NP * NP;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int PPW   = 2 * PART_W + 2;

  if (PART_W < 1 || NP < 1 || (WIDTH % PART_W) != 0 || (NP & (NP - 1)) != 0) begin : g_param_check
    $error("cv32e40p_mult_iter: WIDTH must be PART_W times a power of two");
  end

  mult_iter_state_e    state_reg, state_next;
  logic [SW-1:0]       step_reg;
  logic [WIDTH-1:0]    op_a_reg, op_b_reg, result_reg;
  logic                sign_a_reg, sign_b_reg, high_reg;
  logic [2*WIDTH-1:0]  acc_reg, acc_sum, pp_low;
  logic [PART_W:0]     a_ext [NP];
  logic [PART_W:0]     b_ext [NP];
  logic signed [PART_W:0] chunk_a, chunk_b;
  logic signed [PPW-1:0]  pp;
  logic                last_step, accept;
  int                  idx_a, idx_b;

  // Only the top chunk of a signed operand carries its sign into the extra bit.
  genvar gi;
  for (gi = 0; gi < NP; gi++) begin : g_chunk
    assign a_ext[gi] = {sign_a_reg & 1'(gi == NP - 1) & op_a_reg[gi*PART_W+PART_W-1],
                        op_a_reg[gi*PART_W +: PART_W]};
    assign b_ext[gi] = {sign_b_reg & 1'(gi == NP - 1) & op_b_reg[gi*PART_W+PART_W-1],
                        op_b_reg[gi*PART_W +: PART_W]};
  end

  always_comb begin
    idx_a   = int'(step_reg) % NP;
    idx_b   = int'(step_reg) / NP;
    chunk_a = '0;
    chunk_b = '0;
    for (int k = 0; k < NP; k++) begin
      if (k == idx_a) chunk_a = a_ext[k];
      if (k == idx_b) chunk_b = b_ext[k];
    end
  end

  cv32e40p_mult_pp #(.PART_W(PART_W)) u_pp (
    .op_a    (chunk_a),
    .op_b    (chunk_b),
    .product (pp)
  );

  assign pp_low    = (2*WIDTH)'(pp);
  assign acc_sum   = acc_reg + (pp_low << ((idx_a + idx_b) * PART_W));
  assign last_step = (step_reg == SW'(NSTEP - 1));

  assign ready_o  = (state_reg == MI_IDLE) || ((state_reg == MI_DONE) && ready_i);
  assign valid_o  = (state_reg == MI_DONE);
  assign result_o = result_reg;
  assign accept   = ready_o & valid_i & ~kill_i;

  always_comb begin
    state_next = state_reg;
    if (kill_i) begin
      state_next = MI_IDLE;
    end else begin
      unique case (state_reg)
        MI_IDLE: if (valid_i) state_next = MI_BUSY;
        MI_BUSY: if (last_step) state_next = MI_DONE;
        MI_DONE: if (ready_i) state_next = valid_i ? MI_BUSY : MI_IDLE;
        default: state_next = MI_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= MI_IDLE;
      step_reg   <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      high_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (kill_i) begin
        acc_reg  <= '0;
        step_reg <= '0;
      end else if (accept) begin
        op_a_reg   <= op_a_i;
        op_b_reg   <= op_b_i;
        // Encoding 10 collapses to fully unsigned.
        sign_a_reg <= signed_i[0];
        sign_b_reg <= signed_i[1] & signed_i[0];
        high_reg   <= high_i;
        acc_reg    <= acc_en_i ? {{WIDTH{1'b0}}, op_c_i} : '0;
        step_reg   <= '0;
      end else if (state_reg == MI_BUSY) begin
        acc_reg  <= acc_sum;
        step_reg <= step_reg + 1'b1;
        if (last_step) begin
          result_reg <= high_reg ? acc_sum[2*WIDTH-1:WIDTH] : acc_sum[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_mult_iter.sv
// Bench for cv32e40p_mult_iter: a PART_W=16 and a PART_W=8 instance run the same
// operations; directed vectors, random ops against a 64-bit arithmetic model, handshake corners.
module tb_cv32e40p_mult_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_i = 1'b0, valid8 = 1'b0, kill_i = 1'b0, ready_i = 1'b1;
  logic [W-1:0] op_a = '0, op_b = '0, op_c = '0;
  logic         acc_en = 1'b0, high = 1'b0;
  logic [1:0]   sgn = 2'b00;
  logic         ready_o, valid_o, ready8_o, valid8_o;
  logic [W-1:0] result_o, result8_o;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  cv32e40p_mult_iter #(.WIDTH(W), .PART_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .op_a_i(op_a), .op_b_i(op_b), .op_c_i(op_c), .acc_en_i(acc_en),
    .signed_i(sgn), .high_i(high), .kill_i(kill_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o)
  );

  cv32e40p_mult_iter #(.WIDTH(W), .PART_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid8), .ready_o(ready8_o),
    .op_a_i(op_a), .op_b_i(op_b), .op_c_i(op_c), .acc_en_i(acc_en),
    .signed_i(sgn), .high_i(high), .kill_i(1'b0), .valid_o(valid8_o),
    .ready_i(1'b1), .result_o(result8_o)
  );

  typedef struct {
    logic [W-1:0] a, b, c;
    logic         ae;
    logic [1:0]   s;
    logic         h;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain 64-bit arithmetic: extend each operand as its mode says, multiply, add C, pick half.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, b, c, input logic ae,
                                         input logic [1:0] s, input logic h);
    longint       ea, eb;
    logic [2*W-1:0] p;
    ea = s[0]          ? longint'($signed(a)) : longint'({32'd0, a});
    eb = (s == 2'b11)  ? longint'($signed(b)) : longint'({32'd0, b});
    p  = ea * eb;
    if (ae) p = p + {32'd0, c};
    return h ? p[2*W-1:W] : p[W-1:0];
  endfunction

  // Issue one op to both instances and check result and latency of each.
  task automatic run_op(input string name, input logic [W-1:0] a, b, c, input logic ae,
                        input logic [1:0] s, input logic h, input logic [W-1:0] exp);
    int           lat16, lat8;
    logic [W-1:0] r16, r8;
    bit           got16, got8;
    @(negedge clk);
    chk({name, "/ready16"}, W'(ready_o), 1);
    chk({name, "/ready8"}, W'(ready8_o), 1);
    op_a = a; op_b = b; op_c = c; acc_en = ae; sgn = s; high = h;
    ready_i = 1'b1; valid_i = 1'b1; valid8 = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; valid8 = 1'b0;
    // Inputs must have been latched at accept.
    op_a = $urandom; op_b = $urandom; op_c = $urandom;
    acc_en = 1'($urandom); sgn = 2'($urandom); high = 1'($urandom);
    got16 = 0; got8 = 0; lat16 = -1; lat8 = -1; r16 = '0; r8 = '0;
    for (int k = 0; k < 40 && !(got16 && got8); k++) begin
      if (!got16 && valid_o)  begin got16 = 1; lat16 = k; r16 = result_o;  end
      if (!got8  && valid8_o) begin got8  = 1; lat8  = k; r8  = result8_o; end
      if (!(got16 && got8)) @(negedge clk);
    end
    chk({name, "/lat16"}, W'(lat16), 4);
    chk({name, "/lat8"},  W'(lat8), 16);
    chk({name, "/res16"}, r16, exp);
    chk({name, "/res8"},  r8, exp);
    $display("op %s a=%h b=%h c=%h acc=%0b s=%b h=%0b -> res16=%h res8=%h exp=%h lat=%0d/%0d",
             name, a, b, c, ae, s, h, r16, r8, exp, lat16, lat8);
  endtask

  task automatic wait_valid16(output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (valid_o) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic start16(input logic [W-1:0] a, b);
    @(negedge clk);
    op_a = a; op_b = b; op_c = '0; acc_en = 1'b0; sgn = 2'b00; high = 1'b0;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  initial begin
    int           lat;
    bit           seen;
    logic [W-1:0] a, b, c, e;
    logic         ae, h;
    logic [1:0]   s;

    vecs[0] = '{32'h8000_0000, 32'h8000_0000, 32'h0, 1'b0, 2'b11, 1'b1, 32'h4000_0000};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 2'b00, 1'b1, 32'hFFFF_FFFE};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0000_0001};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 2'b11, 1'b1, 32'h0000_0000};
    vecs[5] = '{32'h3, 32'h5, 32'h7, 1'b1, 2'b00, 1'b0, 32'd22};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2'b00, 1'b1, 32'hFFFF_FFFF};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 2'b10, 1'b1, 32'hFFFF_FFFE};
    vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 2'b01, 1'b0, 32'h0000_0001};
    vecs[9] = '{32'h8000_0000, 32'h0000_0001, 32'h0, 1'b0, 2'b11, 1'b1, 32'hFFFF_FFFF};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset/ready", W'(ready_o), 1);
    chk("reset/valid", W'(valid_o), 0);
    chk("reset/result", result_o, 0);
    chk("reset/valid8", W'(valid8_o), 0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].ae,
             vecs[i].s, vecs[i].h, vecs[i].exp);

    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom; c = $urandom;
      ae = 1'($urandom); s = 2'($urandom_range(0, 3)); h = 1'($urandom);
      if (i % 4 == 0) a = {1'b1, a[W-2:0]};
      e = model(a, b, c, ae, s, h);
      run_op($sformatf("rnd%0d", i), a, b, c, ae, s, h, e);
    end

    // Kill while step 2 is in progress
    start16(32'd5, 32'd7);
    @(negedge clk);
    @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill/ready", W'(ready_o), 1);
    chk("kill/valid", W'(valid_o), 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid_o) seen = 1;
    end
    chk("kill/no_result", W'(seen), 0);
    $display("op kill mid-busy: valid seen=%0d", seen);

    // Kill coincident with valid in IDLE: not accepted
    @(negedge clk);
    op_a = 32'd4; op_b = 32'd4; valid_i = 1'b1; kill_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; kill_i = 1'b0;
    chk("killacc/ready", W'(ready_o), 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid_o) seen = 1;
    end
    chk("killacc/no_result", W'(seen), 0);
    $display("op kill+valid idle: valid seen=%0d", seen);

    run_op("after_kill", 32'd2, 32'd3, 32'd0, 1'b0, 2'b00, 1'b0, 32'd6);

    // Reset in the middle of an operation
    start16(32'd7, 32'd7);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst/valid", W'(valid_o), 0);
    chk("midrst/ready", W'(ready_o), 1);
    chk("midrst/result", result_o, 0);
    chk("midrst/result8", result8_o, 0);
    $display("op reset mid-busy: result=%h", result_o);
    run_op("after_rst", 32'h1234, 32'h10, 32'd0, 1'b0, 2'b00, 1'b0, 32'h1_2340);

    // Consumer stall, then back-to-back accept in DONE
    @(negedge clk);
    ready_i = 1'b0;
    start16(32'd100, 32'd200);
    wait_valid16(lat);
    chk("stall/lat", W'(lat), 4);
    chk("stall/res", result_o, 32'd20000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall/valid%0d", k), W'(valid_o), 1);
      chk($sformatf("stall/hold%0d", k), result_o, 32'd20000);
      chk($sformatf("stall/ready%0d", k), W'(ready_o), 0);
    end
    $display("op stall: result=%h held 5 cycles", result_o);
    ready_i = 1'b1; valid_i = 1'b1; op_a = 32'd9; op_b = 32'd9;
    sgn = 2'b00; high = 1'b0; acc_en = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    chk("b2b/valid_dropped", W'(valid_o), 0);
    chk("b2b/busy", W'(ready_o), 0);
    wait_valid16(lat);
    chk("b2b/lat", W'(lat), 4);
    chk("b2b/res", result_o, 32'd81);
    $display("op back-to-back: result=%h lat=%0d", result_o, lat);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
